// File: rtl/riscv_multicycle_controller.sv
// Multicycle control FSM for an RV32I subset core (lw, sw, R-type, I-type ALU, beq, jal).
// Steps a shared-ALU / shared-memory datapath through one state per cycle and decodes
// every datapath enable and mux select from the current state and instruction fields.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   op, funct3,funct7 instruction fields from the instruction register
//   Zero              ALU zero flag (qualifies beq)
//   mem_ready         memory completes the current access this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
//   ImmSrc, ALUControl datapath controls (combinational)
//   retire            pulse in the final cycle of each instruction
//   illegal           sticky unsupported-opcode flag
//   state_o           current state, for debug
module riscv_multicycle_controller #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       retire,
    output logic       illegal,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StAluWb    = 4'd7,
        StExecI    = 4'd8,
        StJal      = 4'd9,
        StBeq      = 4'd10,
        StTrap     = 4'd11
    } state_e;

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpRType = 7'b0110011;
    localparam logic [6:0] OpIType = 7'b0010011;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpBeq   = 7'b1100011;

    state_e     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic [1:0] alu_op;
    logic       branch;
    logic       pc_update;

    // Only funct7[5] distinguishes add/sub.
    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        alu_op    = 2'b00;
        branch    = 1'b0;
        pc_update = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        retire    = 1'b0;
        case (state_q)
            StFetch: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (mem_ready) begin
                    IRWrite   = 1'b1;
                    pc_update = 1'b1;
                    state_d   = StDecode;
                end
            end
            StDecode: begin
                // Precompute the branch target into ALUOut.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:         state_d = StExecR;
                    OpIType:         state_d = StExecI;
                    OpJal:           state_d = StJal;
                    OpBeq:           state_d = StBeq;
                    default: begin
                        state_d   = StTrap;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            StMemAdr: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (op == OpLoad) ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                AdrSrc = 1'b1;
                if (mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StMemWrite: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = StFetch;
                end
            end
            StExecR: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
                state_d = StAluWb;
            end
            StExecI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
                state_d = StAluWb;
            end
            StAluWb: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
                state_d  = StFetch;
            end
            StJal: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
                state_d   = StAluWb;
            end
            StBeq: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                branch  = 1'b1;
                retire  = 1'b1;
                state_d = StFetch;
            end
            StTrap: state_d = StTrap;
            default: state_d = StFetch;
        endcase
    end

    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7[5]) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    always_comb begin
        case (op)
            OpStore: ImmSrc = 2'b01;
            OpBeq:   ImmSrc = 2'b10;
            OpJal:   ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    assign PCWrite = pc_update | (branch & Zero);
    assign illegal = illegal_q;
    assign state_o = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= state_e'(RESET_STATE);
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// Self-checking bench for riscv_multicycle_controller. A driver plays whole instructions
// (with memory stalls, optional mid-instruction reset) and queues the expected outputs for
// every cycle; a monitor on the falling edge pops and compares.
module tb_riscv_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, retire, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state_o;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] RT   = 7'b0110011;
    localparam logic [6:0] IT   = 7'b0010011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] BEQ  = 7'b1100011;

    localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5;
    localparam int EXECR = 6, ALUWB = 7, EXECI = 8, JALS = 9, BEQS = 10, TRAP = 11;

    typedef struct {
        bit chk;
        int st, pcw, adr, memw, irw, regw, res, asa, asb, imm, alu, ret, ill;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    riscv_multicycle_controller dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct3     (funct3),
        .funct7     (funct7),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .retire     (retire),
        .illegal    (illegal),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    // ALU operation an arithmetic instruction asks for: 0 add, 1 sub, 5 slt, 3 or, 2 and.
    function automatic int arith_op(logic [6:0] o, logic [2:0] f3, logic [6:0] f7);
        case (f3)
            3'b000:  return (o == RT && f7[5]) ? 1 : 0;
            3'b010:  return 5;
            3'b110:  return 3;
            3'b111:  return 2;
            default: return 0;
        endcase
    endfunction

    // Expected outputs for one cycle spent in a given step of an instruction.
    function automatic exp_t model(int st, logic [6:0] o, logic [2:0] f3, logic [6:0] f7,
                                   bit z, bit mr);
        exp_t e = '{default: 0};
        e.chk = 1;
        e.st  = st;
        e.ill = (st == TRAP);
        e.imm = (o == SW) ? 1 : (o == BEQ) ? 2 : (o == JAL) ? 3 : 0;
        case (st)
            FETCH:    begin e.asb = 2; e.res = 2; e.irw = mr; e.pcw = mr; end
            DECODE:   begin e.asa = 1; e.asb = 1; end
            MEMADR:   begin e.asa = 2; e.asb = 1; end
            MEMREAD:  e.adr = 1;
            MEMWB:    begin e.res = 1; e.regw = 1; e.ret = 1; end
            MEMWRITE: begin e.adr = 1; e.memw = 1; e.ret = mr; end
            EXECR:    begin e.asa = 2; e.alu = arith_op(o, f3, f7); end
            EXECI:    begin e.asa = 2; e.asb = 1; e.alu = arith_op(o, f3, f7); end
            ALUWB:    begin e.regw = 1; e.ret = 1; end
            JALS:     begin e.asa = 1; e.asb = 2; e.pcw = 1; end
            BEQS:     begin e.asa = 2; e.alu = 1; e.pcw = z; e.ret = 1; end
            default:  ;
        endcase
        return e;
    endfunction

    task automatic check(string nm, int st, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s in state %0d at %0t: got %0h expected %0h", nm, st, $time, act, exp);
        end
    endtask

    // Monitor: one expected record per driven cycle, compared mid-cycle.
    exp_t me;
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            me = sb_q.pop_front();
            if (me.chk) begin
                check("state_o",    me.st, 32'(state_o),    me.st);
                check("PCWrite",    me.st, 32'(PCWrite),    me.pcw);
                check("AdrSrc",     me.st, 32'(AdrSrc),     me.adr);
                check("MemWrite",   me.st, 32'(MemWrite),   me.memw);
                check("IRWrite",    me.st, 32'(IRWrite),    me.irw);
                check("RegWrite",   me.st, 32'(RegWrite),   me.regw);
                check("ResultSrc",  me.st, 32'(ResultSrc),  me.res);
                check("ALUSrcA",    me.st, 32'(ALUSrcA),    me.asa);
                check("ALUSrcB",    me.st, 32'(ALUSrcB),    me.asb);
                check("ImmSrc",     me.st, 32'(ImmSrc),     me.imm);
                check("ALUControl", me.st, 32'(ALUControl), me.alu);
                check("retire",     me.st, 32'(retire),     me.ret);
                check("illegal",    me.st, 32'(illegal),    me.ill);
            end
        end
    end

    // Play one instruction. fw/mw: stall cycles in fetch / memory access; tl: cycles in TRAP
    // before reset; zf: forced Zero (-1 random); abort: reset at a random step.
    task automatic run_instr(logic [6:0] o, logic [2:0] f3, logic [6:0] f7,
                             int fw, int mw, int tl, int zf, bit abort);
        int   st_q[$];
        int   mr_q[$];
        int   abort_at;
        bit   mr, z, last;
        exp_t e;
        for (int i = 0; i < fw; i++) begin st_q.push_back(FETCH); mr_q.push_back(0); end
        st_q.push_back(FETCH);  mr_q.push_back(1);
        st_q.push_back(DECODE); mr_q.push_back(-1);
        case (o)
            LW: begin
                st_q.push_back(MEMADR); mr_q.push_back(-1);
                for (int i = 0; i < mw; i++) begin st_q.push_back(MEMREAD); mr_q.push_back(0); end
                st_q.push_back(MEMREAD); mr_q.push_back(1);
                st_q.push_back(MEMWB);   mr_q.push_back(-1);
            end
            SW: begin
                st_q.push_back(MEMADR); mr_q.push_back(-1);
                for (int i = 0; i < mw; i++) begin st_q.push_back(MEMWRITE); mr_q.push_back(0); end
                st_q.push_back(MEMWRITE); mr_q.push_back(1);
            end
            RT:  begin st_q.push_back(EXECR); st_q.push_back(ALUWB); mr_q.push_back(-1); mr_q.push_back(-1); end
            IT:  begin st_q.push_back(EXECI); st_q.push_back(ALUWB); mr_q.push_back(-1); mr_q.push_back(-1); end
            JAL: begin st_q.push_back(JALS);  st_q.push_back(ALUWB); mr_q.push_back(-1); mr_q.push_back(-1); end
            BEQ: begin st_q.push_back(BEQS);  mr_q.push_back(-1); end
            default: for (int i = 0; i < tl; i++) begin st_q.push_back(TRAP); mr_q.push_back(-1); end
        endcase
        abort_at = abort ? int'($urandom_range(0, st_q.size() - 1)) : -1;
        foreach (st_q[i]) begin
            @(posedge clk);
            #1;
            mr   = (mr_q[i] < 0) ? 1'($urandom_range(0, 1)) : 1'(mr_q[i]);
            z    = (zf < 0) ? 1'($urandom_range(0, 1)) : 1'(zf);
            last = (i == abort_at) || (st_q[i] == TRAP && i == st_q.size() - 1);
            op        = o;
            funct3    = f3;
            funct7    = f7;
            Zero      = z;
            mem_ready = mr;
            rst       = last;
            e = model(st_q[i], o, f3, f7, z, mr);
            sb_q.push_back(e);
            if (last) break;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] o;
        int         pick;
        exp_t       e;
        rst = 1'b1; mem_ready = 1'b0; op = 7'b0; funct3 = 3'b0; funct7 = 7'b0; Zero = 1'b0;
        // Two reset cycles with memory idle: FETCH with every enable low.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            rst = 1'b1; mem_ready = 1'b0;
            e = model(FETCH, 7'b0, 3'b0, 7'b0, 1'b0, 1'b0);
            sb_q.push_back(e);
        end

        run_instr(RT,  3'b000, 7'b0000000, 0, 0, 0, -1, 0);   // add
        run_instr(RT,  3'b000, 7'b0100000, 0, 0, 0, -1, 0);   // sub
        run_instr(IT,  3'b000, 7'b0100000, 0, 0, 0, -1, 0);   // addi ignores funct7
        run_instr(LW,  3'b010, 7'b0000000, 0, 2, 0, -1, 0);
        run_instr(BEQ, 3'b000, 7'b0000000, 0, 0, 0,  1, 0);
        run_instr(BEQ, 3'b000, 7'b0000000, 0, 0, 0,  0, 0);
        run_instr(7'b1111111, 3'b000, 7'b0, 0, 0, 21, -1, 0); // trap, reset on last cycle
        run_instr(SW,  3'b010, 7'b0000000, 2, 3, 0, -1, 0);
        run_instr(JAL, 3'b000, 7'b0000000, 0, 0, 0, -1, 0);
        run_instr(RT,  3'b010, 7'b0000000, 1, 0, 0, -1, 0);   // slt
        run_instr(RT,  3'b110, 7'b0000000, 0, 0, 0, -1, 0);   // or
        run_instr(IT,  3'b111, 7'b0000000, 0, 0, 0, -1, 0);   // andi

        for (int n = 0; n < 200; n++) begin
            pick = int'($urandom_range(0, 6));
            case (pick)
                0: o = LW;
                1: o = SW;
                2: o = RT;
                3: o = IT;
                4: o = JAL;
                5: o = BEQ;
                default: begin
                    do o = 7'($urandom);
                    while (o inside {LW, SW, RT, IT, JAL, BEQ});
                end
            endcase
            run_instr(o, 3'($urandom), 7'($urandom), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 3)), int'($urandom_range(1, 5)), -1,
                      ($urandom_range(0, 9) == 0));
        end

        @(posedge clk);
        #1;
        rst = 1'b0;
        // Let the monitor drain the queue.
        for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
